// File: rtl/ivd_assay_sequencer.sv
// rtl/ivd_assay_sequencer.sv - dispense/mix/read sequencer for the IVD mixer/detector channels
module ivd_assay_sequencer #(
    parameter int NUM_CH       = 6,
    parameter int DISPENSE_CYC = 16,
    parameter int MIX_CYC      = 64,
    parameter int SETTLE_CYC   = 4,
    parameter int TIMEOUT_CYC  = 255,
    parameter int DET_W        = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [NUM_CH-1:0] valve_sample,
    output logic [NUM_CH-1:0] valve_reagent,
    output logic [2:0]        det_sel,
    input  logic              det_valid,
    input  logic [DET_W-1:0]  det_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [2:0]        res_ch,
    output logic [DET_W-1:0]  res_data,
    output logic              res_timeout
);

    localparam int MAX_A   = (DISPENSE_CYC > MIX_CYC) ? DISPENSE_CYC : MIX_CYC;
    localparam int MAX_B   = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DISPENSE,
        S_MIX,
        S_SETTLE,
        S_WAIT_DET,
        S_EMIT,
        S_FINISH
    } state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [2:0]        ch, ch_nx;
    logic              capture;
    logic              timed_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            ch          <= '0;
            det_sel     <= '0;
            res_ch      <= '0;
            res_data    <= '0;
            res_timeout <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            ch    <= ch_nx;
            // det_sel only moves on SETTLE entry so the settle window starts with it
            if (state_nx == S_SETTLE && state != S_SETTLE)
                det_sel <= ch_nx;
            if (capture) begin
                res_ch      <= ch;
                res_data    <= timed_out ? '0 : det_data;
                res_timeout <= timed_out;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        ch_nx     = ch;
        capture   = 1'b0;
        timed_out = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_DISPENSE;
                    ch_nx    = '0;
                    cnt_nx   = '0;
                end
            end
            S_DISPENSE: begin
                if (cnt == CNT_W'(DISPENSE_CYC - 1)) begin
                    cnt_nx = '0;
                    if (ch == 3'(NUM_CH - 1))
                        state_nx = S_MIX;
                    else
                        ch_nx = ch + 3'd1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            S_MIX: begin
                if (cnt == CNT_W'(MIX_CYC - 1)) begin
                    state_nx = S_SETTLE;
                    ch_nx    = '0;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            S_SETTLE: begin
                if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
                    state_nx = S_WAIT_DET;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            S_WAIT_DET: begin
                // a sample on the last allowed cycle still wins over the timeout
                if (det_valid) begin
                    state_nx = S_EMIT;
                    capture  = 1'b1;
                    cnt_nx   = '0;
                end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_nx  = S_EMIT;
                    capture   = 1'b1;
                    timed_out = 1'b1;
                    cnt_nx    = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            S_EMIT: begin
                if (res_ready) begin
                    cnt_nx = '0;
                    if (ch == 3'(NUM_CH - 1)) begin
                        state_nx = S_FINISH;
                    end else begin
                        state_nx = S_SETTLE;
                        ch_nx    = ch + 3'd1;
                    end
                end
            end
            S_FINISH: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
                ch_nx    = '0;
            end
        endcase

        if (abort && state != S_IDLE) begin
            state_nx  = S_IDLE;
            cnt_nx    = '0;
            ch_nx     = '0;
            capture   = 1'b0;
            timed_out = 1'b0;
        end
    end

    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_FINISH);
        res_valid = (state == S_EMIT);
        for (int i = 0; i < NUM_CH; i++) begin
            valve_sample[i]  = (state == S_DISPENSE) && (ch == 3'(i));
            valve_reagent[i] = (state == S_DISPENSE) && (ch == 3'(i));
        end
    end

endmodule

// File: doc/ivd_assay_sequencer.md
Name: ivd_assay_sequencer

Overview:
- Clocked controller that drives the in-vitro-diagnostics fluidic array from the control side.
- For each channel it opens the sample and reagent inlet valves feeding that channel's mixer, then waits out the mix time.
- It then polls each channel's detector through a select/valid interface and returns one result per channel over a valid/ready stream.
- It sits between the host command logic and the six mixer/detector channel pairs.

Parameters:
- NUM_CH, 6: number of mixer/detector channels (1..8).
- DISPENSE_CYC, 16: cycles each channel's valve pair stays open (>=1).
- MIX_CYC, 64: cycles waited after the last dispense before the first read (>=1).
- SETTLE_CYC, 4: cycles after det_sel changes before det_valid is honoured (>=1).
- TIMEOUT_CYC, 255: maximum cycles waited for det_valid after settle (>=1).
- DET_W, 12: detector sample width.

Ports:
- clk  in  1  clock. Reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle run request, sampled only in IDLE.
- abort  in  1  synchronous abort, effective in any non-IDLE state.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a run completes normally.
- valve_sample  out  NUM_CH  sample inlet valve enables, one per mixer.
- valve_reagent  out  NUM_CH  reagent inlet valve enables, one per mixer.
- det_sel  out  3  detector channel select.
- det_valid  in  1  selected detector has a sample on det_data.
- det_data  in  DET_W  selected detector sample.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_ch  out  3  channel index of the result.
- res_data  out  DET_W  captured detector sample; all zeros on timeout.
- res_timeout  out  1  result is a timeout marker.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, channel index 0, all counters 0.
- FSM states: IDLE, DISPENSE, MIX, SETTLE, WAIT_DET, EMIT, FINISH.
- IDLE: start=1 -> DISPENSE with ch=0. Start is ignored in all other states.
- DISPENSE:
  - valve_sample[ch] and valve_reagent[ch] are high for exactly DISPENSE_CYC cycles, beginning the cycle after start is sampled.
  - Only one channel's valve pair is ever open at a time.
  - At count end, valves close. If ch<NUM_CH-1: ch++ and the next channel opens on the immediately following cycle (no gap). Otherwise -> MIX.
- MIX: all valves closed for MIX_CYC cycles, then -> SETTLE with ch=0.
- SETTLE: det_sel=ch, held for SETTLE_CYC cycles. det_valid is ignored during SETTLE. Then -> WAIT_DET.
- WAIT_DET:
  - det_valid=1: register det_data into res_data, res_timeout=0 -> EMIT.
  - det_valid low for TIMEOUT_CYC consecutive cycles: res_data=0, res_timeout=1 -> EMIT.
  - det_valid=1 on the final timeout cycle counts as valid, not timeout.
- EMIT:
  - res_valid=1 with res_ch=ch. res_data, res_ch and res_timeout are stable while res_valid=1 and res_ready=0.
  - Handshake completes in the cycle where res_valid and res_ready are both 1.
  - On completion: if ch<NUM_CH-1, ch++ -> SETTLE. Otherwise -> FINISH.
  - res_valid is never asserted two consecutive cycles for different results, because SETTLE intervenes.
- FINISH: done=1 for one cycle -> IDLE.
- det_sel holds its last value outside SETTLE/WAIT_DET/EMIT and is reset to 0.
- abort=1 in any non-IDLE state:
  - Next cycle is IDLE with all valves closed, res_valid=0 and done=0.
  - A pending unaccepted result is dropped.
  - abort has priority over every other transition in the same cycle.
- rst=1 mid-run: same effect as abort, plus det_sel=0. rst has priority over abort.
- Counters:
  - Width is sized for the largest of DISPENSE_CYC, MIX_CYC, SETTLE_CYC and TIMEOUT_CYC.
  - Counters clear on every state entry and never wrap within a state.
- Total valve-open cycles per run = NUM_CH*DISPENSE_CYC.

Test Plan:
- Nominal run (defaults), det_valid asserted 2 cycles after each settle, res_ready tied 1:
  - valve pair k is high cycles 1+16k..16+16k, k=0..5.
  - Six results arrive in order, res_ch 0..5, res_timeout=0, res_data equal to the driven samples (0x101..0x106).
  - done pulses once, then busy=0.
- Backpressure: res_ready held 0 for 10 cycles on channel 2 -> res_valid, res_ch=2 and res_data stay stable for all 10 cycles; exactly one transfer; channel 3 select follows.
- Timeout on channel 4: det_valid never asserted for that channel -> after 255 waiting cycles a result is emitted with res_ch=4, res_timeout=1, res_data=0; the run still completes and done pulses.
- Abort during DISPENSE of channel 3 -> next cycle all valves 0, busy=0, no done, no result. A subsequent start restarts at channel 0.
- Boundary cases:
  - det_valid first rises on the 255th wait cycle -> treated as valid.
  - det_valid high during SETTLE -> ignored.
  - start pulsed while busy -> no effect.
- rst asserted in EMIT with res_ready=0 -> next cycle all outputs 0, FSM in IDLE.
